sdft_bin_sequencer: RTL and testbench
=====================================

# sdft_bin_sequencer

Issue and writeback controller for the sliding-DFT processing unit (SPU). For every accepted input sample it forms `x[n] - x[n-N]` from an internal sample history, then sweeps all `FFT_SIZE` bins. For each bin it issues operands (sample difference, twiddle, previous bin value, index, write/display flags) to the SPU, and it takes back the SPU's delayed result stream (`Xk`, `wr_en`, `disp_wr_en`, `idx`) into an internal bin RAM. It sits between the sample source and the SPU, and also drives the display-side bin stream.

## Interface
Parameters:
- `WORD_WIDTH`, 16: sample width; bin values are `2*WORD_WIDTH` as `{re, im}`, with `re` in the upper half.
- `FFT_SIZE`, 512: bins per sweep and history depth N. Power of two, ≥ 8.
- `SPU_LATENCY`, 3: cycles from SPU operand/flag input to SPU output.
- `DISP_DECIM`, 64: one sweep in every `DISP_DECIM` accepted samples is flagged for display.

Ports (`A = $clog2(FFT_SIZE)`):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_sample_valid` in 1: input sample offered.
- `i_sample` in `WORD_WIDTH`: two's-complement sample.
- `o_sample_ready` out 1: sample accepted on a cycle where `valid & ready` is true.
- `o_tw_addr` out A: twiddle ROM address. The ROM is synchronous with 1-cycle read latency.
- `i_twiddle` in `2*WORD_WIDTH`: ROM data for the address presented on the previous cycle.
- `o_sample_diff` out `WORD_WIDTH`: SPU operand.
- `o_twiddle` out `2*WORD_WIDTH`: SPU operand; a combinational copy of `i_twiddle`.
- `o_Xk_prev` out `2*WORD_WIDTH`: SPU operand, taken from the bin RAM read.
- `o_wr_en`, `o_disp_wr_en` out 1: SPU flag inputs.
- `o_idx` out A: SPU index input.
- `i_Xk` in `2*WORD_WIDTH`, `i_wr_en` in 1, `i_disp_wr_en` in 1, `i_idx` in A: SPU outputs.
- `o_disp_valid` out 1, `o_disp_idx` out A, `o_disp_Xk` out `2*WORD_WIDTH`: display bin stream.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- The block holds two internal RAMs: bin RAM (N × `2W`) and history RAM (N × `W`), plus a circular write pointer `hptr`.
- FSM states are CLEAR, IDLE, LOAD, SWEEP and DRAIN.
- **CLEAR** (entered on reset): writes 0 to bin[k] and hist[k] for k = 0..N-1, one entry per cycle (N cycles). It sets `hptr` = 0 and the display counter to 0, then goes to IDLE.
- **IDLE**: `o_sample_ready` = 1. On `valid & ready` the block captures the sample, reads hist[`hptr`], and goes to LOAD.
- **LOAD** (1 cycle):
  - `diff <= sample - hist[hptr]`, truncated to `WORD_WIDTH` (wrap-around, no saturation).
  - Writes the sample into hist[`hptr`] and increments `hptr` modulo N.
  - Latches the sweep display flag: 1 when the display counter is 0. The counter then increments, wrapping at `DISP_DECIM - 1`.
  - Sets k = 0 and goes to SWEEP.
- **SWEEP** (N cycles):
  - In each cycle the block presents address k to bin RAM and `o_tw_addr`.
  - On the following cycle it asserts `o_wr_en` = 1, `o_idx` = k, `o_Xk_prev` = bin[k], `o_sample_diff` = diff, and `o_disp_wr_en` = the sweep display flag.
  - After k = N-1 it goes to DRAIN.
- **DRAIN**: waits until N writebacks of this sweep have been counted, then goes to IDLE. No new sweep starts before the previous bin N-1 write lands, so there is no read-after-write hazard.
- **Writeback**: while `i_wr_en` = 1 and state ≠ CLEAR, the block writes bin[`i_idx`] <= `i_Xk` and increments the writeback count. `i_wr_en` is ignored in CLEAR.
- **Display**: while `i_wr_en & i_disp_wr_en`, the block registers `o_disp_valid` = 1, `o_disp_idx` = `i_idx` and `o_disp_Xk` = `i_Xk`.

## Timing
- Reset values:
  - `o_sample_ready` = 0 and `o_busy` = 1 (CLEAR runs first).
  - All other outputs = 0.
- `o_sample_ready` first rises N+1 cycles after the cycle in which `reset` is sampled low.
- The sample is accepted at cycle t0, and LOAD is t0+1.
- Addresses are issued at t0+2 .. t0+N+1, so SPU operands appear at t0+3 .. t0+N+2.
- The bin-k writeback arrives at t0+3+k+`SPU_LATENCY`.
- `o_sample_ready` returns 1 no earlier than t0+N+4+`SPU_LATENCY`. This gives one sample per N+4+`SPU_LATENCY` cycles when `i_sample_valid` is held.
- `o_wr_en` is high on exactly N contiguous cycles per sweep, and `o_idx` is 0..N-1 in order.
- `o_disp_valid` lags `i_wr_en` by 1 cycle.
- Reset mid-sweep: enters CLEAR next cycle, and all outputs return to reset values. Writebacks still in the SPU pipeline (≤ `SPU_LATENCY` < N cycles) are discarded.

## Test plan
All scenarios use `FFT_SIZE` = 16, `SPU_LATENCY` = 3, `DISP_DECIM` = 4, and a behavioural SPU model: `Xk = twiddle * (Xk_prev + diff)` with latency 3.
- **Reset then idle:** release reset → `o_sample_ready` rises after 17 cycles, `o_busy` falls at the same point, and all other outputs stay 0.
- **First sample 100:** `o_sample_diff` = 100 and `o_Xk_prev` = 0 for all 16 issues, `o_idx` = 0..15 contiguous, and `o_wr_en` high for exactly 16 cycles.
- **Sample 100 followed by 16 zeros:** the 17th sample produces `o_sample_diff` = -100 (0xFF9C). Separately, a pair with new 32767 and old -32768 produces `o_sample_diff` = 0xFFFF (wrap).
- **`i_sample_valid` held high with 20 samples:** accepts are spaced exactly 23 cycles apart, and `o_Xk_prev` for bin k on sweep s equals the model's bin-k result from sweep s-1.
- **Display decimation:** sweeps 0, 4 and 8 each assert `o_disp_wr_en` on all 16 issues and produce exactly 16 `o_disp_valid` pulses; the other sweeps produce none.
- **Reset at SWEEP k = 8:** outputs clear the next cycle, late SPU `i_wr_en` pulses are ignored, and after CLEAR a new sample sees `o_Xk_prev` = 0 for all bins.

Source files
------------

// File: rtl/sdft_bin_sequencer_if.sv
// Operand/writeback bundle between the sliding-DFT bin sequencer, its sample
// source, the twiddle ROM, the SPU and the display sink.
interface sdft_bin_sequencer_if #(
   parameter int WORD_WIDTH = 16,
   parameter int FFT_SIZE   = 512
);
   localparam int A = $clog2(FFT_SIZE);

   logic                    i_sample_valid;
   logic [WORD_WIDTH-1:0]   i_sample;
   logic                    o_sample_ready;
   logic [A-1:0]            o_tw_addr;
   logic [2*WORD_WIDTH-1:0] i_twiddle;
   logic [WORD_WIDTH-1:0]   o_sample_diff;
   logic [2*WORD_WIDTH-1:0] o_twiddle;
   logic [2*WORD_WIDTH-1:0] o_Xk_prev;
   logic                    o_wr_en;
   logic                    o_disp_wr_en;
   logic [A-1:0]            o_idx;
   logic [2*WORD_WIDTH-1:0] i_Xk;
   logic                    i_wr_en;
   logic                    i_disp_wr_en;
   logic [A-1:0]            i_idx;
   logic                    o_disp_valid;
   logic [A-1:0]            o_disp_idx;
   logic [2*WORD_WIDTH-1:0] o_disp_Xk;
   logic                    o_busy;

   modport master (
      input  i_sample_valid, i_sample, i_twiddle, i_Xk, i_wr_en, i_disp_wr_en, i_idx,
      output o_sample_ready, o_tw_addr, o_sample_diff, o_twiddle, o_Xk_prev,
             o_wr_en, o_disp_wr_en, o_idx, o_disp_valid, o_disp_idx, o_disp_Xk, o_busy
   );

   modport slave (
      output i_sample_valid, i_sample, i_twiddle, i_Xk, i_wr_en, i_disp_wr_en, i_idx,
      input  o_sample_ready, o_tw_addr, o_sample_diff, o_twiddle, o_Xk_prev,
             o_wr_en, o_disp_wr_en, o_idx, o_disp_valid, o_disp_idx, o_disp_Xk, o_busy
   );
endinterface

// File: rtl/sdft_bin_sequencer.sv
// Sliding-DFT issue/writeback controller: one x[n]-x[n-N] per accepted sample,
// then a full bin sweep to the SPU with the SPU results written back to bin RAM.
module sdft_bin_sequencer #(
   parameter int WORD_WIDTH  = 16,
   parameter int FFT_SIZE    = 512,
   parameter int SPU_LATENCY = 3,
   parameter int DISP_DECIM  = 64
) (
   input logic                  clk,
   input logic                  reset,
   sdft_bin_sequencer_if.master bus
);
   localparam int A           = $clog2(FFT_SIZE);
   localparam int W2          = 2 * WORD_WIDTH;
   localparam int DW          = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;
   localparam int DRAIN_LIMIT = 2 * SPU_LATENCY + 4;
   localparam int DCW         = $clog2(DRAIN_LIMIT + 1);

   localparam logic [A-1:0]   K_ONE      = A'(1'b1);
   localparam logic [A-1:0]   K_LAST     = A'(FFT_SIZE - 1);
   localparam logic [A:0]     WB_ONE     = (A+1)'(1'b1);
   localparam logic [A:0]     WB_FULL    = (A+1)'(FFT_SIZE);
   localparam logic [A:0]     WB_LAST    = (A+1)'(FFT_SIZE - 1);
   localparam logic [DW-1:0]  DISP_ONE   = DW'(1'b1);
   localparam logic [DW-1:0]  DISP_LAST  = DW'(DISP_DECIM - 1);
   localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1'b1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LIMIT);

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_LOAD  = 3'd2,
      S_SWEEP = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [A-1:0]          k_q;
   logic [A-1:0]          hptr_q;
   logic [DW-1:0]         disp_cnt_q;
   logic                  disp_flag_q;
   logic [WORD_WIDTH-1:0] sample_q;
   logic [WORD_WIDTH-1:0] hist_rd_q;
   logic [WORD_WIDTH-1:0] diff_q;
   logic [A:0]            wb_cnt_q;
   logic [DCW-1:0]        drain_cnt_q;
   logic                  ready_q;
   logic                  busy_q;
   logic                  wr_en_q;
   logic                  dwe_q;
   logic [A-1:0]          idx_q;
   logic [WORD_WIDTH-1:0] sd_q;
   logic [W2-1:0]         xk_prev_q;
   logic                  disp_valid_q;
   logic [A-1:0]          disp_idx_q;
   logic [W2-1:0]         disp_xk_q;

   logic [W2-1:0]         bin_mem  [FFT_SIZE];
   logic [WORD_WIDTH-1:0] hist_mem [FFT_SIZE];

   logic                  accept_s;
   logic                  issue_s;
   logic                  wb_acc_s;
   logic                  wb_done_s;
   logic                  disp_take_s;
   logic                  bin_we_s;
   logic [A-1:0]          bin_wa_s;
   logic [W2-1:0]         bin_wd_s;
   logic                  hist_we_s;
   logic [A-1:0]          hist_wa_s;
   logic [WORD_WIDTH-1:0] hist_wd_s;

   assign accept_s    = (state_q == S_IDLE) & ready_q & bus.i_sample_valid;
   assign issue_s     = (state_q == S_SWEEP);
   // SPU results still in flight when reset hits land during CLEAR and are dropped.
   assign wb_acc_s    = bus.i_wr_en & (state_q != S_CLEAR);
   assign wb_done_s   = (wb_cnt_q == WB_FULL) | (wb_acc_s & (wb_cnt_q == WB_LAST));
   assign disp_take_s = wb_acc_s & bus.i_disp_wr_en;

   // Next-state logic for the sequencing FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: begin
            if (k_q == K_LAST) state_d = S_IDLE;
            else               state_d = S_CLEAR;
         end
         S_IDLE: begin
            if (accept_s) state_d = S_LOAD;
            else          state_d = S_IDLE;
         end
         S_LOAD:  state_d = S_SWEEP;
         S_SWEEP: begin
            if (k_q == K_LAST) state_d = S_DRAIN;
            else               state_d = S_SWEEP;
         end
         // The timeout only fires if the SPU loses a writeback; it keeps the block live.
         S_DRAIN: begin
            if (wb_done_s || (drain_cnt_q == DRAIN_LAST)) state_d = S_IDLE;
            else                                         state_d = S_DRAIN;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Write-port steering for bin and history RAMs.
   always_comb begin
      bin_we_s  = 1'b0;
      bin_wa_s  = k_q;
      bin_wd_s  = {W2{1'b0}};
      hist_we_s = 1'b0;
      hist_wa_s = hptr_q;
      hist_wd_s = sample_q;
      if (state_q == S_CLEAR) begin
         bin_we_s  = 1'b1;
         hist_we_s = 1'b1;
         hist_wa_s = k_q;
         hist_wd_s = {WORD_WIDTH{1'b0}};
      end else begin
         bin_we_s  = wb_acc_s;
         bin_wa_s  = bus.i_idx;
         bin_wd_s  = bus.i_Xk;
         hist_we_s = (state_q == S_LOAD);
      end
   end

   // RAM storage; contents are initialised by the CLEAR sweep, not by reset.
   always_ff @(posedge clk) begin
      if (bin_we_s)  bin_mem[bin_wa_s]   <= bin_wd_s;
      if (hist_we_s) hist_mem[hist_wa_s] <= hist_wd_s;
      if (accept_s)  hist_rd_q           <= hist_mem[hptr_q];
   end

   // Control state, operand issue pipeline and display registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_CLEAR;
         k_q          <= {A{1'b0}};
         hptr_q       <= {A{1'b0}};
         disp_cnt_q   <= {DW{1'b0}};
         disp_flag_q  <= 1'b0;
         sample_q     <= {WORD_WIDTH{1'b0}};
         diff_q       <= {WORD_WIDTH{1'b0}};
         wb_cnt_q     <= {(A+1){1'b0}};
         drain_cnt_q  <= {DCW{1'b0}};
         ready_q      <= 1'b0;
         busy_q       <= 1'b1;
         wr_en_q      <= 1'b0;
         dwe_q        <= 1'b0;
         idx_q        <= {A{1'b0}};
         sd_q         <= {WORD_WIDTH{1'b0}};
         xk_prev_q    <= {W2{1'b0}};
         disp_valid_q <= 1'b0;
         disp_idx_q   <= {A{1'b0}};
         disp_xk_q    <= {W2{1'b0}};
      end else begin
         state_q <= state_d;
         // Ready trails entry to IDLE by one cycle so back-to-back sweeps never overlap writeback.
         ready_q <= (state_q == S_IDLE) & ~accept_s;
         busy_q  <= ~((state_q == S_IDLE) & ~accept_s);

         case (state_q)
            S_CLEAR: begin
               k_q        <= k_q + K_ONE;
               hptr_q     <= {A{1'b0}};
               disp_cnt_q <= {DW{1'b0}};
               wb_cnt_q   <= {(A+1){1'b0}};
            end
            S_LOAD: begin
               diff_q      <= sample_q - hist_rd_q;
               hptr_q      <= hptr_q + K_ONE;
               disp_flag_q <= (disp_cnt_q == {DW{1'b0}});
               disp_cnt_q  <= (disp_cnt_q == DISP_LAST) ? {DW{1'b0}} : disp_cnt_q + DISP_ONE;
               k_q         <= {A{1'b0}};
               wb_cnt_q    <= {(A+1){1'b0}};
            end
            S_SWEEP: begin
               k_q <= k_q + K_ONE;
               if (wb_acc_s) wb_cnt_q <= wb_cnt_q + WB_ONE;
            end
            default: begin
               if (wb_acc_s) wb_cnt_q <= wb_cnt_q + WB_ONE;
            end
         endcase

         if (accept_s) sample_q <= bus.i_sample;
         drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + DRAIN_ONE : {DCW{1'b0}};

         wr_en_q   <= issue_s;
         dwe_q     <= issue_s & disp_flag_q;
         idx_q     <= issue_s ? k_q : {A{1'b0}};
         sd_q      <= issue_s ? diff_q : {WORD_WIDTH{1'b0}};
         xk_prev_q <= issue_s ? bin_mem[k_q] : {W2{1'b0}};

         disp_valid_q <= disp_take_s;
         disp_idx_q   <= disp_take_s ? bus.i_idx : {A{1'b0}};
         disp_xk_q    <= disp_take_s ? bus.i_Xk : {W2{1'b0}};
      end
   end

   assign bus.o_sample_ready = ready_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_tw_addr      = k_q;
   assign bus.o_twiddle      = bus.i_twiddle;
   assign bus.o_sample_diff  = sd_q;
   assign bus.o_Xk_prev      = xk_prev_q;
   assign bus.o_wr_en        = wr_en_q;
   assign bus.o_disp_wr_en   = dwe_q;
   assign bus.o_idx          = idx_q;
   assign bus.o_disp_valid   = disp_valid_q;
   assign bus.o_disp_idx     = disp_idx_q;
   assign bus.o_disp_Xk      = disp_xk_q;
endmodule

// File: tb/tb_sdft_bin_sequencer.sv
// Scoreboard bench for sdft_bin_sequencer with a behavioural twiddle ROM and
// SPU (Xk = twiddle * (Xk_prev + diff), latency 3).
module tb_sdft_bin_sequencer;
   localparam int N = 16;
   localparam int L = 3;
   localparam int D = 4;
   localparam int SPACING = N + 4 + L;

   logic clk;
   logic reset;

   sdft_bin_sequencer_if #(.WORD_WIDTH(16), .FFT_SIZE(N)) bus ();

   sdft_bin_sequencer #(
      .WORD_WIDTH(16), .FFT_SIZE(N), .SPU_LATENCY(L), .DISP_DECIM(D)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] diff;
      logic [31:0] prev;
      logic        dwe;
      int          sweep;
   } iss_t;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] xk;
   } dsp_t;

   iss_t        iss_q[$];
   dsp_t        dsp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          iss_exp = 0, iss_seen = 0;
   int          disp_exp = 0, disp_seen = 0;
   int          sweep_n = 0;
   bit          abort_run = 0;
   logic [31:0] ref_bin  [N];
   logic [15:0] ref_hist [N];
   int          ref_hptr = 0;
   int          ref_dcnt = 0;
   logic [15:0] diff_seen [64];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] tw_of(input logic [3:0] k);
      logic [15:0] re, im;
      re = 16'h4000 + 16'(k) * 16'd613;
      im = 16'hE000 + 16'(k) * 16'd1021;
      return {re, im};
   endfunction

   function automatic logic [31:0] spu_f(input logic [31:0] tw, input logic [31:0] prev,
                                         input logic [15:0] d);
      logic signed [15:0] ar, ai, tr, ti;
      logic signed [31:0] pr, pi;
      ar = prev[31:16] + d;
      ai = prev[15:0];
      tr = tw[31:16];
      ti = tw[15:0];
      pr = ar * tr - ai * ti;
      pi = ar * ti + ai * tr;
      return {pr[30:15], pi[30:15]};
   endfunction

   task automatic ref_reset();
      for (int k = 0; k < N; k++) begin
         ref_bin[k]  = 32'h0;
         ref_hist[k] = 16'h0;
      end
      ref_hptr = 0;
      ref_dcnt = 0;
   endtask

   task automatic push_expect(input logic [15:0] x);
      logic [15:0] d;
      logic        dflag;
      iss_t        e;
      dsp_t        de;
      d = x - ref_hist[ref_hptr];
      ref_hist[ref_hptr] = x;
      ref_hptr = (ref_hptr + 1) % N;
      dflag = (ref_dcnt == 0);
      ref_dcnt = (ref_dcnt + 1) % D;
      for (int k = 0; k < N; k++) begin
         e.idx = 4'(k); e.diff = d; e.prev = ref_bin[k]; e.dwe = dflag; e.sweep = sweep_n;
         iss_q.push_back(e);
         ref_bin[k] = spu_f(tw_of(4'(k)), ref_bin[k], d);
         if (dflag) begin
            de.idx = 4'(k); de.xk = ref_bin[k];
            dsp_q.push_back(de);
            disp_exp++;
         end
      end
      iss_exp += N;
      sweep_n++;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous twiddle ROM, one-cycle latency.
   logic [31:0] rom_q;
   always @(posedge clk) rom_q <= tw_of(bus.o_tw_addr);
   assign bus.i_twiddle = rom_q;

   // Behavioural SPU pipeline; keeps running across DUT resets.
   logic [31:0] p_xk  [L];
   logic        p_we  [L];
   logic        p_dwe [L];
   logic [3:0]  p_idx [L];
   always @(posedge clk) begin
      p_we[0]  <= bus.o_wr_en;
      p_dwe[0] <= bus.o_disp_wr_en;
      p_idx[0] <= bus.o_idx;
      p_xk[0]  <= spu_f(bus.o_twiddle, bus.o_Xk_prev, bus.o_sample_diff);
      for (int i = 1; i < L; i++) begin
         p_we[i]  <= p_we[i-1];
         p_dwe[i] <= p_dwe[i-1];
         p_idx[i] <= p_idx[i-1];
         p_xk[i]  <= p_xk[i-1];
      end
   end
   assign bus.i_wr_en      = p_we[L-1];
   assign bus.i_disp_wr_en = p_dwe[L-1];
   assign bus.i_idx        = p_idx[L-1];
   assign bus.i_Xk         = p_xk[L-1];

   // Output monitor: pops the scoreboard on every issue and display pulse.
   initial begin
      iss_t e;
      dsp_t de;
      int   run_len;
      run_len = 0;
      forever begin
         @(negedge clk);
         if (bus.o_wr_en) begin
            run_len++;
            iss_seen++;
            if (iss_q.size() == 0) chk("issue_unexpected", 64'd1, 64'd0);
            else begin
               e = iss_q.pop_front();
               chk("issue_idx", bus.o_idx, e.idx);
               chk("issue_diff", bus.o_sample_diff, e.diff);
               chk("issue_xk_prev", bus.o_Xk_prev, e.prev);
               chk("issue_disp_wr_en", bus.o_disp_wr_en, e.dwe);
               if (e.idx == 4'd0 && e.sweep < 64) diff_seen[e.sweep] = bus.o_sample_diff;
            end
         end else if (run_len > 0) begin
            if (!abort_run) chk("wr_en_run_length", run_len, N);
            abort_run = 0;
            run_len = 0;
         end
         if (bus.o_disp_valid) begin
            disp_seen++;
            if (dsp_q.size() == 0) chk("disp_unexpected", 64'd1, 64'd0);
            else begin
               de = dsp_q.pop_front();
               chk("disp_idx", bus.o_disp_idx, de.idx);
               chk("disp_xk", bus.o_disp_Xk, de.xk);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string pfx);
      chk({pfx, "_tw_addr"}, bus.o_tw_addr, 64'd0);
      chk({pfx, "_wr_en"}, bus.o_wr_en, 64'd0);
      chk({pfx, "_idx"}, bus.o_idx, 64'd0);
      chk({pfx, "_sample_diff"}, bus.o_sample_diff, 64'd0);
      chk({pfx, "_xk_prev"}, bus.o_Xk_prev, 64'd0);
      chk({pfx, "_disp_wr_en"}, bus.o_disp_wr_en, 64'd0);
      chk({pfx, "_disp_valid"}, bus.o_disp_valid, 64'd0);
      chk({pfx, "_disp_idx"}, bus.o_disp_idx, 64'd0);
      chk({pfx, "_disp_xk"}, bus.o_disp_Xk, 64'd0);
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (!bus.o_sample_ready && w < 300) begin
         step();
         w++;
      end
      if (!bus.o_sample_ready) chk("ready_timeout", 64'd0, 64'd1);
   endtask

   // Offers one sample; returns the accept cycle or -1 if never accepted.
   task automatic send(input logic [15:0] x, input bit hold, output int t_acc);
      int w;
      w = 0;
      bus.i_sample_valid = 1'b1;
      bus.i_sample = x;
      while (!bus.o_sample_ready && w < 300) begin
         step();
         w++;
      end
      if (!bus.o_sample_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
         bus.i_sample_valid = 1'b0;
         t_acc = -1;
      end else begin
         t_acc = cyc;
         push_expect(x);
         @(posedge clk);
         #1;
         if (!hold) bus.i_sample_valid = 1'b0;
      end
   endtask

   initial begin
      int n, t, t_prev, w;
      bit rose;
      logic [15:0] x;
      bus.i_sample_valid = 1'b0;
      bus.i_sample = 16'h0;
      reset = 1'b1;
      ref_reset();
      for (int i = 0; i < 64; i++) diff_seen[i] = 16'h0;

      // Reset then idle
      repeat (5) @(posedge clk);
      step();
      chk("reset_ready", bus.o_sample_ready, 64'd0);
      chk("reset_busy", bus.o_busy, 64'd1);
      check_outputs_zero("reset");
      reset = 1'b0;
      n = 0;
      rose = 0;
      while (n < 100 && !rose) begin
         step();
         n++;
         if (bus.o_sample_ready) rose = 1;
         else chk("busy_during_clear", bus.o_busy, 64'd1);
      end
      chk("ready_rise_cycles", n, 64'd17);
      chk("busy_at_ready", bus.o_busy, 64'd0);
      check_outputs_zero("idle");

      // Sample 100 followed by 16 zeros with idle gaps
      send(16'd100, 1'b0, t);
      for (int j = 0; j < 16; j++) begin
         repeat ($urandom_range(0, 3)) step();
         send(16'd0, 1'b0, t);
      end

      // Held valid, 20 samples, with a 32767 vs -32768 pair 16 apart
      wait_ready();
      t_prev = -1;
      for (int j = 0; j < 20; j++) begin
         if (j == 0)       x = 16'h8000;
         else if (j == 16) x = 16'h7FFF;
         else              x = 16'($urandom);
         send(x, 1'b1, t);
         if (t_prev >= 0 && t >= 0) chk("accept_spacing", t - t_prev, SPACING);
         t_prev = t;
      end
      bus.i_sample_valid = 1'b0;

      // Reset during a display sweep at k = 8
      wait_ready();
      while (ref_dcnt != 0) send(16'($urandom), 1'b0, t);
      send(16'h1234, 1'b0, t);
      w = 0;
      while (bus.o_tw_addr != 4'd8 && w < 100) begin
         step();
         w++;
      end
      chk("reached_k8", bus.o_tw_addr, 64'd8);
      reset = 1'b1;
      abort_run = 1;
      iss_exp -= iss_q.size();
      disp_exp -= dsp_q.size();
      iss_q.delete();
      dsp_q.delete();
      ref_reset();
      @(posedge clk);
      #1;
      chk("midreset_ready", bus.o_sample_ready, 64'd0);
      chk("midreset_busy", bus.o_busy, 64'd1);
      check_outputs_zero("midreset");
      step();
      reset = 1'b0;
      wait_ready();
      send(16'h0005, 1'b0, t);

      // Drain and final accounting
      w = 0;
      while ((iss_q.size() != 0 || dsp_q.size() != 0 || !bus.o_sample_ready) && w < 500) begin
         step();
         w++;
      end
      chk("issue_queue_empty", iss_q.size(), 64'd0);
      chk("disp_queue_empty", dsp_q.size(), 64'd0);
      chk("issue_count", iss_seen, iss_exp);
      chk("disp_count", disp_seen, disp_exp);
      chk("diff_first_100", diff_seen[0], 64'h0064);
      chk("diff_minus_100", diff_seen[16], 64'hFF9C);
      chk("diff_wrap", diff_seen[33], 64'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
